// File: rtl/io_pkg.sv
// Shared MMIO input widths for the input conditioner and the LSU.
// Keeps switch/button port widths consistent across the core.
package io_pkg;
  localparam int N_SW  = 32;
  localparam int N_BTN = 4;
endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-FF synchronizer followed by a counter debounce.
// The level only changes after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit RST_VAL         = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          deb;
  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1  <= RST_VAL;
      s2  <= RST_VAL;
      deb <= RST_VAL;
      cnt <= '0;
    end else begin
      s1 <= i_raw;
      s2 <= s1;
      // Any sample matching the current level restarts the run.
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign o_level = deb;

endmodule

// File: rtl/io_input_conditioner.sv
// Conditions raw switches/buttons into debounced levels, press pulses
// and software-cleared sticky press flags for the MMIO input port.
module io_input_conditioner
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_SW-1:0]  i_sw_raw,
  input  logic [N_BTN-1:0] i_btn_raw,
  input  logic [N_BTN-1:0] i_evt_clr,
  output logic [N_SW-1:0]  o_io_sw,
  output logic [N_BTN-1:0] o_io_btn,
  output logic [N_BTN-1:0] o_btn_press,
  output logic [N_BTN-1:0] o_btn_event
);

  localparam int N_ALL = N_SW + N_BTN;

  logic [N_ALL-1:0] raw_all;
  logic [N_ALL-1:0] lvl_all;
  logic [N_BTN-1:0] deb_btn;
  logic [N_BTN-1:0] deb_d;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] evt_q;

  assign raw_all = {i_btn_raw, i_sw_raw};

  // Button syncs reset to the released pin level so reset never looks like a press.
  for (genvar g = 0; g < N_ALL; g++) begin : g_deb
    localparam bit RV = (g >= N_SW) ? BTN_ACTIVE_LOW : 1'b0;
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RST_VAL        (RV)
    ) u_deb (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_raw  (raw_all[g]),
      .o_level(lvl_all[g])
    );
  end

  assign deb_btn =
    lvl_all[N_ALL-1:N_SW] ^ {N_BTN{BTN_ACTIVE_LOW}};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      deb_d   <= '0;
      press_q <= '0;
      evt_q   <= '0;
    end else begin
      deb_d   <= deb_btn;
      press_q <= deb_btn & ~deb_d;
      evt_q   <= (evt_q & ~i_evt_clr) | press_q;
    end
  end

  assign o_io_sw     = lvl_all[N_SW-1:0];
  assign o_io_btn    = deb_btn;
  assign o_btn_press = press_q;
  assign o_btn_event = evt_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner: table vectors, corner sequences
// and random stimulus against a timestamp-based reference model.
module tb_io_input_conditioner;

  localparam int DC = 4;
  localparam int NA = 36;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sw_raw;
  logic [3:0]  btn_raw;
  logic [3:0]  evt_clr;
  logic [31:0] o_io_sw;
  logic [3:0]  o_io_btn;
  logic [3:0]  o_btn_press;
  logic [3:0]  o_btn_event;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  io_input_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sw_raw   (sw_raw),
    .i_btn_raw  (btn_raw),
    .i_evt_clr  (evt_clr),
    .o_io_sw    (o_io_sw),
    .o_io_btn   (o_io_btn),
    .o_btn_press(o_btn_press),
    .o_btn_event(o_btn_event)
  );

  // Reference model: a pin's level flips once its synchronized value
  // has differed from the level for DC whole cycles since the last
  // cycle it matched (or since the last flip / reset).
  int          t = 0;
  logic [NA-1:0] ms1, ms2, mdeb;
  int          mark[NA];
  logic [3:0]  mdebd, mpress, mevent;

  task automatic model_edge();
    logic [NA-1:0] raw;
    logic [3:0]    lvl;
    raw = {btn_raw, sw_raw};
    t++;
    if (rst) begin
      ms1 = {4'hF, 32'h0};
      ms2 = ms1;
      mdeb = ms1;
      for (int b = 0; b < NA; b++) mark[b] = t;
      mdebd = '0;
      mpress = '0;
      mevent = '0;
    end else begin
      lvl = ~mdeb[35:32];
      mevent = (mevent & ~evt_clr) | mpress;
      mpress = lvl & ~mdebd;
      mdebd = lvl;
      for (int b = 0; b < NA; b++) begin
        if (ms2[b] == mdeb[b]) mark[b] = t;
        else if (t - mark[b] >= DC) begin
          mdeb[b] = ms2[b];
          mark[b] = t;
        end
      end
      ms2 = ms1;
      ms1 = raw;
    end
  endtask

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic chk_all(string tag, logic [31:0] es,
                         logic [3:0] eb, logic [3:0] ep,
                         logic [3:0] ee);
    chk({tag, "_sw"}, o_io_sw, es);
    chk({tag, "_btn"}, {28'h0, o_io_btn}, {28'h0, eb});
    chk({tag, "_press"}, {28'h0, o_btn_press}, {28'h0, ep});
    chk({tag, "_event"}, {28'h0, o_btn_event}, {28'h0, ee});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk_all($sformatf("model@%0d", t), mdeb[31:0],
            ~mdeb[35:32], mpress, mevent);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] sw;
    logic [3:0]  btn;
    logic [3:0]  clr;
    int          cyc;
    logic [31:0] e_sw;
    logic [3:0]  e_btn;
    logic [3:0]  e_press;
    logic [3:0]  e_evt;
  } vec_t;

  vec_t tbl[12];
  int   np;

  initial begin
    tbl[0]  = '{1'b1, 32'h0,  4'hF, 4'h0, 3,  32'h0,  4'h0, 4'h0, 4'h0};
    tbl[1]  = '{1'b0, 32'h0,  4'hF, 4'h0, 20, 32'h0,  4'h0, 4'h0, 4'h0};
    tbl[2]  = '{1'b0, 32'hA5, 4'hF, 4'h0, 5,  32'h0,  4'h0, 4'h0, 4'h0};
    tbl[3]  = '{1'b0, 32'hA5, 4'hF, 4'h0, 1,  32'hA5, 4'h0, 4'h0, 4'h0};
    tbl[4]  = '{1'b0, 32'hA5, 4'hE, 4'h0, 6,  32'hA5, 4'h1, 4'h0, 4'h0};
    tbl[5]  = '{1'b0, 32'hA5, 4'hE, 4'h0, 1,  32'hA5, 4'h1, 4'h1, 4'h0};
    tbl[6]  = '{1'b0, 32'hA5, 4'hE, 4'h0, 1,  32'hA5, 4'h1, 4'h0, 4'h1};
    tbl[7]  = '{1'b0, 32'hA5, 4'hF, 4'h0, 5,  32'hA5, 4'h1, 4'h0, 4'h1};
    tbl[8]  = '{1'b0, 32'hA5, 4'hF, 4'h0, 1,  32'hA5, 4'h0, 4'h0, 4'h1};
    tbl[9]  = '{1'b0, 32'hA5, 4'hF, 4'h0, 3,  32'hA5, 4'h0, 4'h0, 4'h1};
    tbl[10] = '{1'b0, 32'hA5, 4'hF, 4'h1, 1,  32'hA5, 4'h0, 4'h0, 4'h0};
    tbl[11] = '{1'b0, 32'hA5, 4'hF, 4'h0, 2,  32'hA5, 4'h0, 4'h0, 4'h0};

    rst = 1'b1;
    sw_raw = '0;
    btn_raw = 4'hF;
    evt_clr = '0;

    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst;
      sw_raw = tbl[i].sw;
      btn_raw = tbl[i].btn;
      evt_clr = tbl[i].clr;
      ticks(tbl[i].cyc);
      chk_all($sformatf("tbl%0d", i), tbl[i].e_sw,
              tbl[i].e_btn, tbl[i].e_press, tbl[i].e_evt);
    end

    // Bounce on button 0, then hold pressed
    btn_raw[0] = 1'b0; tick();
    btn_raw[0] = 1'b1; tick();
    btn_raw[0] = 1'b0; tick();
    btn_raw[0] = 1'b1; tick();
    btn_raw[0] = 1'b0;
    ticks(5);
    chk("bounce_early", {31'h0, o_io_btn[0]}, 32'h0);
    tick();
    chk("bounce_rise", {31'h0, o_io_btn[0]}, 32'h1);
    np = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      np += int'(o_btn_press[0]);
    end
    chk("bounce_npress", np, 1);
    chk("bounce_event", {31'h0, o_btn_event[0]}, 32'h1);

    // Sticky clear, then set and clear in the same cycle
    evt_clr = 4'h1; tick();
    evt_clr = 4'h0;
    chk("clr_event", {31'h0, o_btn_event[0]}, 32'h0);
    btn_raw[0] = 1'b1; ticks(8);
    btn_raw[0] = 1'b0; ticks(7);
    chk("repress_pulse", {31'h0, o_btn_press[0]}, 32'h1);
    chk("repress_evt0", {31'h0, o_btn_event[0]}, 32'h0);
    evt_clr = 4'h1; tick();
    evt_clr = 4'h0;
    chk("set_wins", {31'h0, o_btn_event[0]}, 32'h1);
    tick();
    chk("set_hold", {31'h0, o_btn_event[0]}, 32'h1);

    // Reset in the middle of a button 2 debounce
    btn_raw = 4'hF; ticks(8);
    btn_raw[2] = 1'b0; ticks(4);
    chk("mid_pre", {31'h0, o_io_btn[2]}, 32'h0);
    rst = 1'b1; tick();
    rst = 1'b0;
    np = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      np += int'(o_btn_press[2]);
    end
    chk("mid_early", {31'h0, o_io_btn[2]}, 32'h0);
    tick();
    chk("mid_rise", {31'h0, o_io_btn[2]}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      tick();
      np += int'(o_btn_press[2]);
    end
    chk("mid_npress", np, 1);

    // Release of button 2
    btn_raw = 4'hF; ticks(5);
    chk("rel_hold", {28'h0, o_io_btn}, 32'h4);
    np = 0;
    tick();
    chk("rel_fall", {28'h0, o_io_btn}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      np += int'(o_btn_press != 4'h0);
      tick();
    end
    chk("rel_nopress", np, 0);
    chk("rel_event", {28'h0, o_btn_event}, 32'h4);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0)
        btn_raw = btn_raw ^ 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0)
        sw_raw = $urandom;
      evt_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
